// File: rtl/traffic_phase_ctrl.sv
`default_nettype none
// =============================================================================
// traffic_phase_ctrl : round-robin green/yellow/all-red phase controller
// Rev 1.0
// =============================================================================
module traffic_phase_ctrl #(
   parameter int N_APPR = 4,
   parameter int T_GMIN = 4,
   parameter int T_GMAX = 8,
   parameter int T_YEL  = 2,
   parameter int T_ARED = 1
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      tick,
   input  logic [N_APPR-1:0]         car_req,
   output logic [N_APPR-1:0]         red,
   output logic [N_APPR-1:0]         yellow,
   output logic [N_APPR-1:0]         green,
   output logic [$clog2(N_APPR)-1:0] active,
   output logic                      phase_start
);

   localparam int AW    = $clog2(N_APPR);
   localparam int T_BIG = (T_GMAX > T_YEL) ? ((T_GMAX > T_ARED) ? T_GMAX : T_ARED)
                                           : ((T_YEL  > T_ARED) ? T_YEL  : T_ARED);
   localparam int TW    = $clog2(T_BIG + 1);

   localparam logic [TW-1:0]     c_gmin_last = TW'(T_GMIN - 1);
   localparam logic [TW-1:0]     c_gmax_last = TW'(T_GMAX - 1);
   localparam logic [TW-1:0]     c_yel_last  = TW'(T_YEL - 1);
   localparam logic [TW-1:0]     c_ared_last = TW'(T_ARED - 1);
   localparam logic [AW:0]       c_n         = (AW+1)'(N_APPR);
   localparam logic [N_APPR-1:0] c_one       = N_APPR'(1);

   typedef enum logic [1:0] {
      S_GREEN  = 2'd0,
      S_YELLOW = 2'd1,
      S_ALLRED = 2'd2
   } state_t;

   state_t              r_state, w_state_nx;
   logic [TW-1:0]       r_timer, w_timer_nx;
   logic [AW-1:0]       r_active, w_active_nx, w_rr_pick;
   logic [N_APPR-1:0]   r_pending, w_pending_nx;
   logic [N_APPR-1:0]   r_red, r_yellow, r_green;
   logic [N_APPR-1:0]   w_grn_nx, w_yel_nx;
   logic [N_APPR-1:0]   w_act_mask, w_nx_mask, w_rot;
   logic [2*N_APPR-1:0] w_dbl, w_shift;
   logic [AW:0]         w_off, w_sum;
   logic                r_ps;
   logic                w_other_pend, w_enter_green;

   assign w_act_mask   = c_one << r_active;
   assign w_other_pend = |(r_pending & ~w_act_mask);

   // Rotate pending so bit 0 is approach active+1; the lowest set bit is the winner.
   assign w_dbl   = {r_pending, r_pending};
   assign w_shift = w_dbl >> ({1'b0, r_active} + (AW+1)'(1));
   assign w_rot   = w_shift[N_APPR-1:0];

   always_comb begin
      w_off = '0;
      for (int k = N_APPR - 1; k >= 0; k--) begin
         if (w_rot[k]) w_off = (AW+1)'(k);
      end
      w_sum = {1'b0, r_active} + (AW+1)'(1) + w_off;
      if (w_sum >= c_n) w_sum = w_sum - c_n;
      w_rr_pick = w_sum[AW-1:0];
   end

   always_comb begin
      w_state_nx    = r_state;
      w_timer_nx    = r_timer;
      w_active_nx   = r_active;
      w_enter_green = 1'b0;
      if (tick) begin
         case (r_state)
            S_GREEN: begin
               if ((r_timer >= c_gmin_last) && w_other_pend &&
                   (!car_req[r_active] || (r_timer == c_gmax_last))) begin
                  w_state_nx = S_YELLOW;
                  w_timer_nx = '0;
               end else if (r_timer != c_gmax_last) begin
                  w_timer_nx = r_timer + TW'(1);
               end
            end
            S_YELLOW: begin
               if (r_timer == c_yel_last) begin
                  w_state_nx = S_ALLRED;
                  w_timer_nx = '0;
               end else begin
                  w_timer_nx = r_timer + TW'(1);
               end
            end
            S_ALLRED: begin
               if (r_timer == c_ared_last) begin
                  w_state_nx    = S_GREEN;
                  w_timer_nx    = '0;
                  w_enter_green = 1'b1;
                  if (|r_pending) w_active_nx = w_rr_pick;
               end else begin
                  w_timer_nx = r_timer + TW'(1);
               end
            end
            default: begin
               w_state_nx = S_GREEN;
               w_timer_nx = '0;
            end
         endcase
      end
      w_nx_mask    = c_one << w_active_nx;
      // Entering green clears that approach's request even if it is asserted now.
      w_pending_nx = (r_pending | car_req) & ~(w_enter_green ? w_nx_mask : '0);
      w_grn_nx     = (w_state_nx == S_GREEN)  ? w_nx_mask : '0;
      w_yel_nx     = (w_state_nx == S_YELLOW) ? w_nx_mask : '0;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state   <= S_GREEN;
         r_timer   <= '0;
         r_active  <= '0;
         r_pending <= '0;
         r_green   <= c_one;
         r_yellow  <= '0;
         r_red     <= ~c_one;
         r_ps      <= 1'b1;
      end else begin
         r_state   <= w_state_nx;
         r_timer   <= w_timer_nx;
         r_active  <= w_active_nx;
         r_pending <= w_pending_nx;
         r_green   <= w_grn_nx;
         r_yellow  <= w_yel_nx;
         r_red     <= ~(w_grn_nx | w_yel_nx);
         r_ps      <= (w_state_nx != r_state);
      end
   end

   assign red         = r_red;
   assign yellow      = r_yellow;
   assign green       = r_green;
   assign active      = r_active;
   assign phase_start = r_ps;

endmodule
`default_nettype wire

// File: tb/tb_traffic_phase_ctrl.sv
`default_nettype none
// =============================================================================
// tb_traffic_phase_ctrl : vector table, corner sequences and random run vs model
// Rev 1.0
// =============================================================================
module tb_traffic_phase_ctrl;

   localparam int N    = 4;
   localparam int GMIN = 4;
   localparam int GMAX = 8;
   localparam int YEL  = 2;
   localparam int ARED = 1;

   logic         clk;
   logic         reset;
   logic         tick;
   logic [N-1:0] car_req;
   logic [N-1:0] red, yellow, green;
   logic [1:0]   active;
   logic         phase_start;

   int n_checks = 0;
   int n_errors = 0;

   // Reference model: phase 0=green 1=yellow 2=all-red, ticks spent in phase.
   int       m_phase, m_cnt, m_cur;
   bit [3:0] m_pend;
   bit       m_ps;

   traffic_phase_ctrl #(
      .N_APPR(N), .T_GMIN(GMIN), .T_GMAX(GMAX), .T_YEL(YEL), .T_ARED(ARED)
   ) u_dut (
      .clk(clk), .reset(reset), .tick(tick), .car_req(car_req),
      .red(red), .yellow(yellow), .green(green),
      .active(active), .phase_start(phase_start)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_step(input bit r, input bit t, input bit [3:0] q);
      bit [3:0] np;
      bit       others;
      if (r) begin
         m_phase = 0; m_cnt = 0; m_cur = 0; m_pend = '0; m_ps = 1;
         return;
      end
      np   = m_pend | q;
      m_ps = 0;
      if (t) begin
         case (m_phase)
            0: begin
               others = 0;
               for (int j = 0; j < N; j++) if (j != m_cur && m_pend[j]) others = 1;
               if (m_cnt >= GMIN-1 && others && (!q[m_cur] || m_cnt == GMAX-1)) begin
                  m_phase = 1; m_cnt = 0; m_ps = 1;
               end else if (m_cnt < GMAX-1) m_cnt++;
            end
            1: begin
               if (m_cnt == YEL-1) begin m_phase = 2; m_cnt = 0; m_ps = 1; end
               else m_cnt++;
            end
            default: begin
               if (m_cnt == ARED-1) begin
                  m_phase = 0; m_cnt = 0; m_ps = 1;
                  for (int k = 1; k <= N; k++) begin
                     if (m_pend[(m_cur + k) % N]) begin
                        m_cur = (m_cur + k) % N;
                        break;
                     end
                  end
                  np[m_cur] = 0;
               end else m_cnt++;
            end
         endcase
      end
      m_pend = np;
   endtask

   // One clock: drive inputs, advance model at the edge, compare #1 later.
   task automatic do_cycle(input bit r, input bit t, input bit [3:0] q);
      logic [3:0] eg, ey;
      reset = r; tick = t; car_req = q;
      @(posedge clk);
      model_step(r, t, q);
      #1;
      eg = (m_phase == 0) ? (4'b0001 << m_cur) : 4'b0000;
      ey = (m_phase == 1) ? (4'b0001 << m_cur) : 4'b0000;
      check("model", {17'd0, red, yellow, green, active, phase_start},
            {17'd0, ~(eg | ey), ey, eg, 2'(m_cur), m_ps});
   endtask

   typedef struct {
      bit       rst;
      bit       tk;
      bit [3:0] req;
      bit [3:0] g;
      bit [3:0] y;
      bit [1:0] a;
      bit       ps;
   } vec_t;

   vec_t tbl[22];

   int          cnt, ticks, nord, ps_seen;
   int          order[2];
   bit          gap_ok[2];
   bit          prev_allred, t;
   logic [3:0]  q;

   initial begin
      reset = 1'b1; tick = 1'b1; car_req = '0;

      // Single pulse to approach 2, then reset landing in the 2nd yellow cycle.
      tbl[0]  = '{1'b1, 1'b1, 4'h0, 4'b0001, 4'b0000, 2'd0, 1'b1};
      tbl[1]  = '{1'b0, 1'b1, 4'h4, 4'b0001, 4'b0000, 2'd0, 1'b0};
      tbl[2]  = '{1'b0, 1'b1, 4'h0, 4'b0001, 4'b0000, 2'd0, 1'b0};
      tbl[3]  = '{1'b0, 1'b1, 4'h0, 4'b0001, 4'b0000, 2'd0, 1'b0};
      tbl[4]  = '{1'b0, 1'b1, 4'h0, 4'b0000, 4'b0001, 2'd0, 1'b1};
      tbl[5]  = '{1'b0, 1'b1, 4'h0, 4'b0000, 4'b0001, 2'd0, 1'b0};
      tbl[6]  = '{1'b0, 1'b1, 4'h0, 4'b0000, 4'b0000, 2'd0, 1'b1};
      tbl[7]  = '{1'b0, 1'b1, 4'h0, 4'b0100, 4'b0000, 2'd2, 1'b1};
      tbl[8]  = '{1'b0, 1'b1, 4'h0, 4'b0100, 4'b0000, 2'd2, 1'b0};
      tbl[9]  = '{1'b1, 1'b1, 4'h0, 4'b0001, 4'b0000, 2'd0, 1'b1};
      tbl[10] = '{1'b0, 1'b1, 4'h4, 4'b0001, 4'b0000, 2'd0, 1'b0};
      tbl[11] = '{1'b0, 1'b1, 4'h0, 4'b0001, 4'b0000, 2'd0, 1'b0};
      tbl[12] = '{1'b0, 1'b1, 4'h0, 4'b0001, 4'b0000, 2'd0, 1'b0};
      tbl[13] = '{1'b0, 1'b1, 4'h0, 4'b0000, 4'b0001, 2'd0, 1'b1};
      tbl[14] = '{1'b0, 1'b1, 4'h0, 4'b0000, 4'b0001, 2'd0, 1'b0};
      tbl[15] = '{1'b1, 1'b1, 4'h0, 4'b0001, 4'b0000, 2'd0, 1'b1};
      for (int i = 16; i < 22; i++)
         tbl[i] = '{1'b0, 1'b1, 4'h0, 4'b0001, 4'b0000, 2'd0, 1'b0};

      for (int i = 0; i < 22; i++) begin
         do_cycle(tbl[i].rst, tbl[i].tk, tbl[i].req);
         check($sformatf("vec%0d", i), {20'd0, red, yellow, green, active, phase_start},
               {20'd0, ~(tbl[i].g | tbl[i].y), tbl[i].y, tbl[i].g, tbl[i].a, tbl[i].ps});
      end

      // Idle after reset: approach 0 keeps green, no further phase starts.
      do_cycle(1, 1, 4'h0);
      ps_seen = 0;
      for (int i = 0; i < 50; i++) begin
         do_cycle(0, 1, 4'h0);
         if (phase_start) ps_seen++;
      end
      check("idle_phase_starts", ps_seen, 0);
      check("idle_green", green, 4'b0001);

      // Contention with approach 0 still requesting: green runs to the maximum.
      do_cycle(1, 1, 4'b0011);
      cnt = (green == 4'b0001) ? 1 : 0;
      for (int i = 0; i < 40; i++) begin
         do_cycle(0, 1, 4'b0011);
         if (green != 4'b0001) break;
         cnt++;
      end
      check("gmax_dwell", cnt, GMAX);
      check("gmax_then_yellow", yellow, 4'b0001);
      for (int i = 0; i < 10; i++) begin
         if (green != 4'b0000) break;
         do_cycle(0, 1, 4'b0011);
      end
      check("gmax_next_green", green, 4'b0010);

      // Pulse on approaches 1 and 3: serviced 1 then 3, all-red before each.
      do_cycle(1, 1, 4'h0);
      do_cycle(0, 1, 4'b1010);
      nord = 0; prev_allred = 0;
      for (int i = 0; i < 60 && nord < 2; i++) begin
         prev_allred = (green == 4'b0000) && (yellow == 4'b0000);
         do_cycle(0, 1, 4'h0);
         if (phase_start && green != 4'b0000) begin
            order[nord]  = active;
            gap_ok[nord] = prev_allred;
            nord++;
         end
      end
      check("rr_services", nord, 2);
      if (nord == 2) begin
         check("rr_first", order[0], 1);
         check("rr_second", order[1], 3);
         check("rr_gap_first", gap_ok[0], 1);
         check("rr_gap_second", gap_ok[1], 1);
      end

      // Tick every other cycle: green[1] first shows in cycle 13 after 7 ticks.
      do_cycle(1, 1, 4'h0);
      cnt = 0; ticks = 0;
      for (int i = 0; i < 40; i++) begin
         t = (cnt % 2 == 0);
         do_cycle(0, t, 4'b0010);
         if (t) ticks++;
         cnt++;
         if (green == 4'b0010) break;
      end
      check("halftick_cycles", cnt, 13);
      check("halftick_ticks", ticks, 7);

      // Random run against the model.
      for (int i = 0; i < 600; i++) begin
         for (int b = 0; b < N; b++) q[b] = ($urandom_range(0, 5) == 0);
         do_cycle($urandom_range(0, 79) == 0, $urandom_range(0, 3) != 0, q);
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish, checks=%0d", n_checks);
      $fatal(1);
   end

endmodule
`default_nettype wire
